// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle main controller: select codes, opcodes, states.
// The bne opcode constant is only decoded when MC_CTRL_BNE_EN is defined.
package mc_ctrl_pkg;

   localparam logic [1:0] NPC_SEL_NORMAL    = 2'd0;
   localparam logic [1:0] NPC_SEL_RELATIVE  = 2'd1;
   localparam logic [1:0] NPC_SEL_NRELATIVE = 2'd2;
   localparam logic [1:0] NPC_SEL_REG       = 2'd3;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;

   localparam logic [1:0] ALU_OP_ADD = 2'd0;
   localparam logic [1:0] ALU_OP_SUB = 2'd1;
   localparam logic [1:0] ALU_OP_OR  = 2'd2;

   localparam logic [1:0] EXT_OP_ZERO = 2'd0;
   localparam logic [1:0] EXT_OP_SIGN = 2'd1;
   localparam logic [1:0] EXT_OP_LUI  = 2'd2;

   localparam logic [1:0] REG_DST_RT = 2'd0;
   localparam logic [1:0] REG_DST_RD = 2'd1;
   localparam logic [1:0] REG_DST_RA = 2'd2;

   localparam logic [1:0] WD_SEL_ALU = 2'd0;
   localparam logic [1:0] WD_SEL_DM  = 2'd1;
   localparam logic [1:0] WD_SEL_PC  = 2'd2;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_EXE_R   = 4'd2,
      S_EXE_I   = 4'd3,
      S_ALU_WB  = 4'd4,
      S_MEM_ADR = 4'd5,
      S_MEM_RD  = 4'd6,
      S_MEM_WB  = 4'd7,
      S_MEM_WR  = 4'd8,
      S_BRANCH  = 4'd9,
      S_JUMP    = 4'd10,
      S_HALT    = 4'd15
   } state_e;

   // One-hot instruction class; exactly one field is set for any ins value.
   typedef struct packed {
      logic addu;
      logic subu;
      logic jr;
      logic ori;
      logic lui;
      logic lw;
      logic sw;
      logic beq;
      logic bne;
      logic j;
      logic jal;
      logic illegal;
   } ins_class_t;

   function automatic logic [5:0] ins_op(input logic [31:0] ins);
      return ins[31:26];
   endfunction

   function automatic logic [5:0] ins_funct(input logic [31:0] ins);
      return ins[5:0];
   endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> fetch/datapath bundle: instruction and flag in, enables and selects out.
// master = controller side, slave = fetch unit / datapath side.
interface mc_ctrl_if #(
   parameter int STATE_W = 4
);
   logic [31:0]        ins;
   logic               zero;
   logic [1:0]         npc_sel;
   logic               pc_write;
   logic               rgs_ins_write;
   logic               reg_write;
   logic [1:0]         reg_dst;
   logic [1:0]         wd_sel;
   logic               alu_src;
   logic [1:0]         alu_op;
   logic [1:0]         ext_op;
   logic               mem_write;
   logic               illegal;
   logic [STATE_W-1:0] state;

   modport master (
      input  ins, zero,
      output npc_sel, pc_write, rgs_ins_write, reg_write, reg_dst, wd_sel,
             alu_src, alu_op, ext_op, mem_write, illegal, state
   );

   modport slave (
      output ins, zero,
      input  npc_sel, pc_write, rgs_ins_write, reg_write, reg_dst, wd_sel,
             alu_src, alu_op, ext_op, mem_write, illegal, state
   );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction classifier: ins -> one-hot instruction class.
// bne (op 05) is recognised only when MC_CTRL_BNE_EN is defined; otherwise it is illegal.
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
(
   input  logic [31:0] ins,
   output ins_class_t  cls
);

   logic [5:0] op;
   logic [5:0] funct;
   logic       unused_ins_fields;

   assign op                = ins_op(ins);
   assign funct             = ins_funct(ins);
   assign unused_ins_fields = ^ins[25:6];

   always_comb begin
      cls = '0;
      case (op)
         OP_RTYPE: begin
            case (funct)
               FN_ADDU: cls.addu    = 1'b1;
               FN_SUBU: cls.subu    = 1'b1;
               FN_JR:   cls.jr      = 1'b1;
               default: cls.illegal = 1'b1;
            endcase
         end
         OP_ORI: cls.ori = 1'b1;
         OP_LUI: cls.lui = 1'b1;
         OP_LW:  cls.lw  = 1'b1;
         OP_SW:  cls.sw  = 1'b1;
         OP_BEQ: cls.beq = 1'b1;
         OP_BNE: begin
`ifdef MC_CTRL_BNE_EN
            cls.bne = 1'b1;
`else
            cls.illegal = 1'b1;
`endif
         end
         OP_J:    cls.j       = 1'b1;
         OP_JAL:  cls.jal     = 1'b1;
         default: cls.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/writeback.
// Build option MC_CTRL_BNE_EN adds bne (op 05) as a branch on ~zero.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_FETCH   | load IR, PC <= PC+4
// S_DECODE  | classify ins, no enables; flags unsupported instructions
// S_EXE_R   | ALU on rs/rt (addu/subu)
// S_EXE_I   | ALU on rs/extended imm (ori/lui)
// S_ALU_WB  | write ALU result to rd (R) or rt (I)
// S_MEM_ADR | address = rs + sign-extended imm
// S_MEM_RD  | data memory read in flight
// S_MEM_WB  | write loaded data to rt
// S_MEM_WR  | single-cycle data memory write
// S_BRANCH  | compare rs/rt, PC-relative load on taken
// S_JUMP    | j/jal/jr PC load, jal links PC into $31
// S_HALT    | terminal after an unsupported instruction (ILLEGAL_STALL=1)
module mc_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int          STATE_W       = 4,
   parameter int unsigned ILLEGAL_STALL = 0
) (
   input  logic     clk,
   input  logic     reset,
   mc_ctrl_if.master bus
);

   state_e     state_q;
   state_e     state_d;
   ins_class_t cls;

   logic [1:0] npc_sel;
   logic       pc_write;
   logic       rgs_ins_write;
   logic       reg_write;
   logic [1:0] reg_dst;
   logic [1:0] wd_sel;
   logic       alu_src;
   logic [1:0] alu_op;
   logic [1:0] ext_op;
   logic       mem_write;
   logic       illegal;
   logic [STATE_W-1:0] state_out;

   mc_ctrl_decode u_decode (
      .ins (bus.ins),
      .cls (cls)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      npc_sel       = NPC_SEL_NORMAL;
      pc_write      = 1'b0;
      rgs_ins_write = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = REG_DST_RT;
      wd_sel        = WD_SEL_ALU;
      alu_src       = 1'b0;
      alu_op        = ALU_OP_ADD;
      ext_op        = EXT_OP_ZERO;
      mem_write     = 1'b0;
      illegal       = 1'b0;

      case (state_q)
         S_FETCH: begin
            rgs_ins_write = 1'b1;
            pc_write      = 1'b1;
            npc_sel       = NPC_SEL_NORMAL;
            state_d       = S_DECODE;
         end
         S_DECODE: begin
            illegal = cls.illegal;
            if (cls.addu || cls.subu) begin
               state_d = S_EXE_R;
            end else if (cls.ori || cls.lui) begin
               state_d = S_EXE_I;
            end else if (cls.lw || cls.sw) begin
               state_d = S_MEM_ADR;
            end else if (cls.beq || cls.bne) begin
               state_d = S_BRANCH;
            end else if (cls.j || cls.jal || cls.jr) begin
               state_d = S_JUMP;
            end else begin
               state_d = (ILLEGAL_STALL != 0) ? S_HALT : S_FETCH;
            end
         end
         S_EXE_R: begin
            alu_src = 1'b0;
            alu_op  = cls.subu ? ALU_OP_SUB : ALU_OP_ADD;
            state_d = S_ALU_WB;
         end
         S_EXE_I: begin
            alu_src = 1'b1;
            alu_op  = ALU_OP_OR;
            ext_op  = cls.lui ? EXT_OP_LUI : EXT_OP_ZERO;
            state_d = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_write = 1'b1;
            wd_sel    = WD_SEL_ALU;
            reg_dst   = (cls.addu || cls.subu) ? REG_DST_RD : REG_DST_RT;
            state_d   = S_FETCH;
         end
         S_MEM_ADR: begin
            alu_src = 1'b1;
            ext_op  = EXT_OP_SIGN;
            alu_op  = ALU_OP_ADD;
            state_d = cls.sw ? S_MEM_WR : (cls.lw ? S_MEM_RD : S_FETCH);
         end
         S_MEM_RD: begin
            state_d = S_MEM_WB;
         end
         S_MEM_WB: begin
            reg_write = 1'b1;
            wd_sel    = WD_SEL_DM;
            reg_dst   = REG_DST_RT;
            state_d   = S_FETCH;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_BRANCH: begin
            alu_src  = 1'b0;
            alu_op   = ALU_OP_SUB;
            npc_sel  = NPC_SEL_RELATIVE;
            pc_write = cls.bne ? ~bus.zero : bus.zero;
            state_d  = S_FETCH;
         end
         S_JUMP: begin
            pc_write = 1'b1;
            if (cls.jr) begin
               npc_sel = NPC_SEL_REG;
            end else begin
               npc_sel = NPC_SEL_NRELATIVE;
            end
            // The fetch unit already holds old PC+4, which is the jal link value.
            if (cls.jal) begin
               reg_write = 1'b1;
               reg_dst   = REG_DST_RA;
               wd_sel    = WD_SEL_PC;
            end
            state_d = S_FETCH;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase

      // While reset is held the register already shows FETCH; suppress its enables
      // so nothing is loaded on the reset edge.
      if (reset) begin
         npc_sel       = NPC_SEL_NORMAL;
         pc_write      = 1'b0;
         rgs_ins_write = 1'b0;
         reg_write     = 1'b0;
         reg_dst       = REG_DST_RT;
         wd_sel        = WD_SEL_ALU;
         alu_src       = 1'b0;
         alu_op        = ALU_OP_ADD;
         ext_op        = EXT_OP_ZERO;
         mem_write     = 1'b0;
         illegal       = 1'b0;
      end
   end

   always_comb begin
      state_out      = '0;
      state_out[3:0] = state_q;
   end

   assign bus.npc_sel       = npc_sel;
   assign bus.pc_write      = pc_write;
   assign bus.rgs_ins_write = rgs_ins_write;
   assign bus.reg_write     = reg_write;
   assign bus.reg_dst       = reg_dst;
   assign bus.wd_sel        = wd_sel;
   assign bus.alu_src       = alu_src;
   assign bus.alu_op        = alu_op;
   assign bus.ext_op        = ext_op;
   assign bus.mem_write     = mem_write;
   assign bus.illegal       = illegal;
   assign bus.state         = state_out;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: vector table, reset/halt sequences and a randomized instruction stream
// checked against an instruction-level cycle-trace model.
module tb_mc_ctrl;

   typedef struct packed {
      logic [3:0] state;
      logic [1:0] npc_sel;
      logic       pc_write;
      logic       rgs_ins_write;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [1:0] wd_sel;
      logic       alu_src;
      logic [1:0] alu_op;
      logic [1:0] ext_op;
      logic       mem_write;
      logic       illegal;
   } out_t;

   typedef struct {
      logic [31:0] ins;
      logic        zero;
      int          lat;
      out_t        last;
   } vec_t;

   typedef enum {K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_BNE,
                 K_J, K_JAL, K_ILL} kind_e;

   logic clk;
   logic reset0;
   logic reset1;
   int   n_tests;
   int   n_fail;
   out_t exp_q[$];

   mc_ctrl_if #(.STATE_W(4)) bus0 ();
   mc_ctrl_if #(.STATE_W(4)) bus1 ();

   mc_ctrl #(.STATE_W(4), .ILLEGAL_STALL(0)) dut0 (
      .clk   (clk),
      .reset (reset0),
      .bus   (bus0.master)
   );

   mc_ctrl #(.STATE_W(4), .ILLEGAL_STALL(1)) dut1 (
      .clk   (clk),
      .reset (reset1),
      .bus   (bus1.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   function automatic out_t mk(input int st, input int npc, input int pcw, input int irw,
                               input int rw, input int rdst, input int wds, input int asrc,
                               input int aop, input int ext, input int mw, input int ill);
      out_t o;
      o.state         = 4'(st);
      o.npc_sel       = 2'(npc);
      o.pc_write      = 1'(pcw);
      o.rgs_ins_write = 1'(irw);
      o.reg_write     = 1'(rw);
      o.reg_dst       = 2'(rdst);
      o.wd_sel        = 2'(wds);
      o.alu_src       = 1'(asrc);
      o.alu_op        = 2'(aop);
      o.ext_op        = 2'(ext);
      o.mem_write     = 1'(mw);
      o.illegal       = 1'(ill);
      return o;
   endfunction

   function automatic out_t sample(input int which);
      out_t o;
      if (which == 0) begin
         o.state = bus0.state; o.npc_sel = bus0.npc_sel; o.pc_write = bus0.pc_write;
         o.rgs_ins_write = bus0.rgs_ins_write; o.reg_write = bus0.reg_write;
         o.reg_dst = bus0.reg_dst; o.wd_sel = bus0.wd_sel; o.alu_src = bus0.alu_src;
         o.alu_op = bus0.alu_op; o.ext_op = bus0.ext_op; o.mem_write = bus0.mem_write;
         o.illegal = bus0.illegal;
      end else begin
         o.state = bus1.state; o.npc_sel = bus1.npc_sel; o.pc_write = bus1.pc_write;
         o.rgs_ins_write = bus1.rgs_ins_write; o.reg_write = bus1.reg_write;
         o.reg_dst = bus1.reg_dst; o.wd_sel = bus1.wd_sel; o.alu_src = bus1.alu_src;
         o.alu_op = bus1.alu_op; o.ext_op = bus1.ext_op; o.mem_write = bus1.mem_write;
         o.illegal = bus1.illegal;
      end
      return o;
   endfunction

   task automatic check(input string name, input int which, input out_t exp);
      out_t act;
      act = sample(which);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got st=%0d npc=%0d pcw=%b irw=%b rw=%b rdst=%0d wds=%0d asrc=%b aop=%0d ext=%0d mw=%b ill=%b, expected st=%0d npc=%0d pcw=%b irw=%b rw=%b rdst=%0d wds=%0d asrc=%b aop=%0d ext=%0d mw=%b ill=%b",
                  name, act.state, act.npc_sel, act.pc_write, act.rgs_ins_write, act.reg_write,
                  act.reg_dst, act.wd_sel, act.alu_src, act.alu_op, act.ext_op, act.mem_write,
                  act.illegal, exp.state, exp.npc_sel, exp.pc_write, exp.rgs_ins_write,
                  exp.reg_write, exp.reg_dst, exp.wd_sel, exp.alu_src, exp.alu_op, exp.ext_op,
                  exp.mem_write, exp.illegal);
      end
   endtask

   task automatic check_state(input string name, input int which, input int exp_st);
      out_t act;
      act = sample(which);
      n_tests++;
      if (act.state !== 4'(exp_st)) begin
         n_fail++;
         $display("FAIL %s: state got %0d expected %0d", name, act.state, exp_st);
      end
   endtask

   function automatic kind_e classify(input logic [31:0] ins);
      logic [5:0] op;
      logic [5:0] fn;
      op = ins[31:26];
      fn = ins[5:0];
      if (op == 6'h00) begin
         if (fn == 6'h21) return K_ADDU;
         if (fn == 6'h23) return K_SUBU;
         if (fn == 6'h08) return K_JR;
         return K_ILL;
      end
      if (op == 6'h0D) return K_ORI;
      if (op == 6'h0F) return K_LUI;
      if (op == 6'h23) return K_LW;
      if (op == 6'h2B) return K_SW;
      if (op == 6'h04) return K_BEQ;
`ifdef MC_CTRL_BNE_EN
      if (op == 6'h05) return K_BNE;
`endif
      if (op == 6'h02) return K_J;
      if (op == 6'h03) return K_JAL;
      return K_ILL;
   endfunction

   // Expected per-cycle outputs of one whole instruction, from FETCH to its last state.
   task automatic build_trace(input logic [31:0] ins, input logic z);
      kind_e k;
      k = classify(ins);
      exp_q.delete();
      exp_q.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, (k == K_ILL) ? 1 : 0));
      case (k)
         K_ADDU, K_SUBU: begin
            exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, (k == K_SUBU) ? 1 : 0, 0, 0, 0));
            exp_q.push_back(mk(4, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
         end
         K_ORI, K_LUI: begin
            exp_q.push_back(mk(3, 0, 0, 0, 0, 0, 0, 1, 2, (k == K_LUI) ? 2 : 0, 0, 0));
            exp_q.push_back(mk(4, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
         end
         K_LW: begin
            exp_q.push_back(mk(5, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
            exp_q.push_back(mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            exp_q.push_back(mk(7, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
         end
         K_SW: begin
            exp_q.push_back(mk(5, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
            exp_q.push_back(mk(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
         end
         K_BEQ: exp_q.push_back(mk(9, 1, z ? 1 : 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
         K_BNE: exp_q.push_back(mk(9, 1, z ? 0 : 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
         K_J:   exp_q.push_back(mk(10, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         K_JAL: exp_q.push_back(mk(10, 2, 1, 0, 1, 2, 2, 0, 0, 0, 0, 0));
         K_JR:  exp_q.push_back(mk(10, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         default: ;
      endcase
   endtask

   function automatic logic [31:0] rand_ins();
      logic [4:0]  rs, rt, rd;
      logic [15:0] imm;
      logic [25:0] tgt;
      rs  = 5'($urandom);
      rt  = 5'($urandom);
      rd  = 5'($urandom);
      imm = 16'($urandom);
      tgt = 26'($urandom);
      case ($urandom_range(0, 11))
         0:  return {6'h00, rs, rt, rd, 5'h00, 6'h21};
         1:  return {6'h00, rs, rt, rd, 5'h00, 6'h23};
         2:  return {6'h00, rs, 15'h0000, 6'h08};
         3:  return {6'h0D, rs, rt, imm};
         4:  return {6'h0F, 5'h00, rt, imm};
         5:  return {6'h23, rs, rt, imm};
         6:  return {6'h2B, rs, rt, imm};
         7:  return {6'h04, rs, rt, imm};
         8:  return {6'h05, rs, rt, imm};
         9:  return {6'h02, tgt};
         10: return {6'h03, tgt};
         default: return $urandom;
      endcase
   endfunction

   initial begin
      vec_t vecs[15];
      logic [31:0] ins;
      logic        z;

      n_tests = 0;
      n_fail  = 0;
      reset0 = 1'b1;
      reset1 = 1'b1;
      bus0.ins = 32'h0; bus0.zero = 1'b0;
      bus1.ins = 32'h0; bus1.zero = 1'b0;

      vecs[0]  = '{32'h00221821, 1'b0, 4, mk(4, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0)};
      vecs[1]  = '{32'h00221823, 1'b0, 4, mk(4, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0)};
      vecs[2]  = '{32'h3422000F, 1'b0, 4, mk(4, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0)};
      vecs[3]  = '{32'h3C011234, 1'b1, 4, mk(4, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0)};
      vecs[4]  = '{32'h8C220004, 1'b0, 5, mk(7, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0)};
      vecs[5]  = '{32'hAC220004, 1'b0, 4, mk(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)};
      vecs[6]  = '{32'h10220003, 1'b0, 3, mk(9, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0)};
      vecs[7]  = '{32'h10220003, 1'b1, 3, mk(9, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0)};
      vecs[8]  = '{32'h08000C10, 1'b0, 3, mk(10, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
      vecs[9]  = '{32'h0C000C10, 1'b0, 3, mk(10, 2, 1, 0, 1, 2, 2, 0, 0, 0, 0, 0)};
      vecs[10] = '{32'h03E00008, 1'b0, 3, mk(10, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
      vecs[11] = '{32'hFC000000, 1'b0, 2, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
      vecs[12] = '{32'h00221822, 1'b0, 2, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
`ifdef MC_CTRL_BNE_EN
      vecs[13] = '{32'h14220003, 1'b0, 3, mk(9, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0)};
      vecs[14] = '{32'h14220003, 1'b1, 3, mk(9, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0)};
`else
      vecs[13] = '{32'h14220003, 1'b0, 2, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
      vecs[14] = '{32'h14220003, 1'b1, 2, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
`endif

      // Reset held: FETCH state with every enable low.
      @(negedge clk);
      #1 check("reset_hold", 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      reset0 = 1'b0;

      foreach (vecs[i]) begin
         bus0.ins  = vecs[i].ins;
         bus0.zero = vecs[i].zero;
         for (int c = 0; c < vecs[i].lat; c++) begin
            if (c == vecs[i].lat - 1) begin
               #1 check($sformatf("vec%0d_last", i), 0, vecs[i].last);
            end
            @(negedge clk);
         end
         #1 check_state($sformatf("vec%0d_ret", i), 0, 0);
      end

      // Reset in the middle of EXE_R.
      bus0.ins  = 32'h00221821;
      bus0.zero = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1 check_state("mid_exe_r", 0, 2);
      reset0 = 1'b1;
      #1 check("rst_async", 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      #1 check("rst_edge", 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      reset0 = 1'b0;
      #1 check("rst_fetch", 0, mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      #1 check("rst_decode", 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      #1 check_state("rst_resume", 0, 0);

      // Randomized instruction stream against the trace model.
      for (int n = 0; n < 250; n++) begin
         ins = rand_ins();
         z   = 1'($urandom);
         build_trace(ins, z);
         bus0.ins  = ins;
         bus0.zero = z;
         foreach (exp_q[k]) begin
            #1 check($sformatf("rnd%0d_c%0d_ins%08h", n, k, ins), 0, exp_q[k]);
            @(negedge clk);
         end
      end
      #1 check_state("rnd_end", 0, 0);

      // ILLEGAL_STALL=1 instance: unsupported instruction parks in HALT until reset.
      bus1.ins  = 32'hFC000000;
      bus1.zero = 1'b0;
      reset1    = 1'b0;
      #1 check("halt_fetch", 1, mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      #1 check("halt_decode", 1, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         bus1.ins = 32'h00221821;
         #1 check($sformatf("halt_hold%0d", c), 1, mk(15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      end
      reset1 = 1'b1;
      #1 check("halt_reset", 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      bus1.ins = 32'h03E00008;
      reset1   = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1 check("halt_recover_jr", 1, mk(10, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      #1 check_state("halt_recover_ret", 1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
